// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline: ALU opcodes, jump kinds
// and the bit positions of the architectural flags.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int PC_W   = 32;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_MOV  = 4'd1,
        ALU_NOT  = 4'd2,
        ALU_INC  = 4'd3,
        ALU_DEC  = 4'd4,
        ALU_ADD  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_SHL  = 4'd9,
        ALU_SHR  = 4'd10,
        ALU_SETC = 4'd11,
        ALU_CLRC = 4'd12
    } alu_op_t;

    typedef enum logic [2:0] {
        JUMP_NONE = 3'd0,
        JUMP_JMP  = 3'd1,
        JUMP_JZ   = 3'd2,
        JUMP_JN   = 3'd3,
        JUMP_JC   = 3'd4
    } jump_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU. Produces the result and the flag value the
// register would take if this operation is allowed to update flags.
module alu
    import cpu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  shamt,
    input  logic [3:0]  op,
    input  logic [2:0]  flags_in,
    output logic [15:0] result,
    output logic [2:0]  flags_next
);

    alu_op_t     op_e;
    logic [16:0] wide;
    logic [16:0] shr_ext;
    logic        carry;
    logic        zn_update;

    always_comb begin
        op_e      = alu_op_t'(op);
        wide      = '0;
        shr_ext   = '0;
        carry     = flags_in[FLAG_C];
        zn_update = 1'b1;
        case (op_e)
            ALU_NOP:  zn_update = 1'b0;
            ALU_MOV:  wide = {1'b0, b};
            ALU_NOT:  wide = {1'b0, ~a};
            ALU_INC: begin
                wide  = {1'b0, a} + 17'd1;
                carry = wide[16];
            end
            ALU_DEC: begin
                wide  = {1'b0, a} - 17'd1;
                carry = wide[16];
            end
            ALU_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                carry = wide[16];
            end
            // bit 16 of the 17-bit difference is the borrow
            ALU_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                carry = wide[16];
            end
            ALU_AND:  wide = {1'b0, a & b};
            ALU_OR:   wide = {1'b0, a | b};
            ALU_SHL: begin
                wide = {1'b0, a} << shamt;
                if (shamt != 4'd0)
                    carry = wide[16];
            end
            // a guard bit below the LSB catches the last bit shifted out
            ALU_SHR: begin
                shr_ext = {a, 1'b0} >> shamt;
                wide    = {1'b0, shr_ext[16:1]};
                if (shamt != 4'd0)
                    carry = shr_ext[0];
            end
            ALU_SETC: begin
                carry     = 1'b1;
                zn_update = 1'b0;
            end
            ALU_CLRC: begin
                carry     = 1'b0;
                zn_update = 1'b0;
            end
            default:  zn_update = 1'b0;
        endcase

        result             = wide[15:0];
        flags_next         = flags_in;
        flags_next[FLAG_C] = carry;
        if (zn_update) begin
            flags_next[FLAG_Z] = (wide[15:0] == 16'd0);
            flags_next[FLAG_N] = wide[15];
        end
    end

endmodule

// File: rtl/var_reg.sv
// Generic pipeline register: synchronous active-high clear, load on enable.
module var_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, architectural flag register, jump resolution and the
// EX/MEM pipeline buffer with stall/flush handling.
module execute_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] read_data1,
    input  logic [15:0] read_data2,
    input  logic [15:0] immediate,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic        flag_enable,
    input  logic [2:0]  jump_type,
    input  logic [31:0] jump_target,
    input  logic        interrupt,
    input  logic        restore_flags_en,
    input  logic [2:0]  restore_flags,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic        memory_push,
    input  logic        memory_pop,
    input  logic [1:0]  memory_address_select,
    input  logic [1:0]  memory_write_src_select,
    input  logic        reg_write,
    input  logic [1:0]  wb_sel,
    input  logic        outport_enable,
    input  logic [2:0]  reg_write_address,
    input  logic [31:0] pc,
    input  logic [15:0] input_port,
    output logic        memory_read_out,
    output logic        memory_write_out,
    output logic        memory_push_out,
    output logic        memory_pop_out,
    output logic [1:0]  memory_address_select_out,
    output logic [1:0]  memory_write_src_select_out,
    output logic        reg_write_out,
    output logic [1:0]  wb_sel_out,
    output logic        outport_enable_out,
    output logic [2:0]  reg_write_address_out,
    output logic [31:0] pc_out,
    output logic [15:0] input_port_out,
    output logic [15:0] alu_value_out,
    output logic [15:0] read_data1_out,
    output logic [15:0] read_data2_out,
    output logic [15:0] LDM_value_out,
    output logic [2:0]  flags,
    output logic [2:0]  saved_flags,
    output logic        pc_choose_ex,
    output logic [31:0] pc_from_mux_ex
);

    localparam int DATA_BITS = 64;
    localparam int CTRL_BITS = 15;
    localparam int PASS_BITS = 48;

    logic [15:0] operand_b;
    logic [15:0] alu_result;
    logic [2:0]  alu_flags;

    assign operand_b = alu_src ? immediate : read_data2;

    alu u_alu (
        .a          (read_data1),
        .b          (operand_b),
        .shamt      (immediate[3:0]),
        .op         (alu_op),
        .flags_in   (flags),
        .result     (alu_result),
        .flags_next (alu_flags)
    );

    // Jump resolution against the flag register as it stands this cycle
    logic       jump_blocked;
    logic       cond_taken;
    logic       jump_taken;
    logic [2:0] clear_mask;

    assign jump_blocked = reset | stall | flush;

    always_comb begin
        cond_taken = 1'b0;
        jump_taken = 1'b0;
        clear_mask = '0;
        case (jump_t'(jump_type))
            JUMP_JMP: jump_taken = 1'b1;
            JUMP_JZ: begin
                cond_taken         = flags[FLAG_Z];
                clear_mask[FLAG_Z] = 1'b1;
            end
            JUMP_JN: begin
                cond_taken         = flags[FLAG_N];
                clear_mask[FLAG_N] = 1'b1;
            end
            JUMP_JC: begin
                cond_taken         = flags[FLAG_C];
                clear_mask[FLAG_C] = 1'b1;
            end
            default: ;
        endcase
        if (jump_blocked) begin
            cond_taken = 1'b0;
            jump_taken = 1'b0;
        end else begin
            jump_taken = jump_taken | cond_taken;
        end
    end

    assign pc_choose_ex   = jump_taken;
    assign pc_from_mux_ex = jump_blocked ? 32'd0 : jump_target;

    always_ff @(posedge clk) begin
        if (reset)
            flags <= '0;
        else if (restore_flags_en)
            flags <= restore_flags;
        else if (!(stall || flush)) begin
            if (flag_enable)
                flags <= alu_flags;
            else if (cond_taken)
                flags <= flags & ~clear_mask;
        end
    end

    // Snapshot ignores stall and captures the pre-update value
    always_ff @(posedge clk) begin
        if (reset)
            saved_flags <= '0;
        else if (interrupt)
            saved_flags <= flags;
    end

    // EX/MEM buffer: flush overrides stall by forcing a load of zeros
    logic                 buf_en;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic [CTRL_BITS-1:0] ctrl_d, ctrl_q;
    logic [PASS_BITS-1:0] pass_d, pass_q;

    assign buf_en = flush | ~stall;

    assign data_d = flush ? '0 : {alu_result, read_data1, read_data2, immediate};
    assign ctrl_d = flush ? '0 : {memory_read, memory_write, memory_push, memory_pop,
                                  memory_address_select, memory_write_src_select,
                                  reg_write, wb_sel, outport_enable, reg_write_address};
    assign pass_d = flush ? '0 : {pc, input_port};

    var_reg #(.WIDTH(DATA_BITS)) u_data_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (buf_en),
        .d      (data_d),
        .q      (data_q)
    );

    var_reg #(.WIDTH(CTRL_BITS)) u_ctrl_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (buf_en),
        .d      (ctrl_d),
        .q      (ctrl_q)
    );

    var_reg #(.WIDTH(PASS_BITS)) u_pass_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (buf_en),
        .d      (pass_d),
        .q      (pass_q)
    );

    assign {alu_value_out, read_data1_out, read_data2_out, LDM_value_out} = data_q;
    assign {memory_read_out, memory_write_out, memory_push_out, memory_pop_out,
            memory_address_select_out, memory_write_src_select_out,
            reg_write_out, wb_sel_out, outport_enable_out, reg_write_address_out} = ctrl_q;
    assign {pc_out, input_port_out} = pass_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// stall/flush/interrupt/reset sequences and a randomized run against a model.
module tb_execute_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [15:0] read_data1, read_data2, immediate;
    logic [3:0]  alu_op;
    logic        alu_src, flag_enable;
    logic [2:0]  jump_type;
    logic [31:0] jump_target;
    logic        interrupt, restore_flags_en;
    logic [2:0]  restore_flags;
    logic        memory_read, memory_write, memory_push, memory_pop;
    logic [1:0]  memory_address_select, memory_write_src_select;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        outport_enable;
    logic [2:0]  reg_write_address;
    logic [31:0] pc;
    logic [15:0] input_port;

    logic        memory_read_out, memory_write_out, memory_push_out, memory_pop_out;
    logic [1:0]  memory_address_select_out, memory_write_src_select_out;
    logic        reg_write_out;
    logic [1:0]  wb_sel_out;
    logic        outport_enable_out;
    logic [2:0]  reg_write_address_out;
    logic [31:0] pc_out;
    logic [15:0] input_port_out, alu_value_out, read_data1_out, read_data2_out, LDM_value_out;
    logic [2:0]  flags, saved_flags;
    logic        pc_choose_ex;
    logic [31:0] pc_from_mux_ex;

    int n_vec = 0;
    int n_err = 0;

    execute_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
        .alu_op(alu_op), .alu_src(alu_src), .flag_enable(flag_enable),
        .jump_type(jump_type), .jump_target(jump_target), .interrupt(interrupt),
        .restore_flags_en(restore_flags_en), .restore_flags(restore_flags),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_push(memory_push), .memory_pop(memory_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .reg_write(reg_write), .wb_sel(wb_sel), .outport_enable(outport_enable),
        .reg_write_address(reg_write_address), .pc(pc), .input_port(input_port),
        .memory_read_out(memory_read_out), .memory_write_out(memory_write_out),
        .memory_push_out(memory_push_out), .memory_pop_out(memory_pop_out),
        .memory_address_select_out(memory_address_select_out),
        .memory_write_src_select_out(memory_write_src_select_out),
        .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
        .outport_enable_out(outport_enable_out),
        .reg_write_address_out(reg_write_address_out), .pc_out(pc_out),
        .input_port_out(input_port_out), .alu_value_out(alu_value_out),
        .read_data1_out(read_data1_out), .read_data2_out(read_data2_out),
        .LDM_value_out(LDM_value_out), .flags(flags), .saved_flags(saved_flags),
        .pc_choose_ex(pc_choose_ex), .pc_from_mux_ex(pc_from_mux_ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0;
        read_data1 = 0; read_data2 = 0; immediate = 0;
        alu_op = 4'd0; alu_src = 0; flag_enable = 0;
        jump_type = 3'd0; jump_target = 0;
        interrupt = 0; restore_flags_en = 0; restore_flags = 0;
        memory_read = 0; memory_write = 0; memory_push = 0; memory_pop = 0;
        memory_address_select = 0; memory_write_src_select = 0;
        reg_write = 0; wb_sel = 0; outport_enable = 0; reg_write_address = 0;
        pc = 0; input_port = 0;
    endtask

    // Reference ALU from plain integer arithmetic; flags are {C,N,Z}
    task automatic model_alu(input int op, input int a, input int b, input int s,
                             input logic [2:0] f, output int r, output logic [2:0] nf);
        int  c;
        int  sum;
        bit  zn;
        c = f[2]; zn = 1; r = 0;
        case (op)
            0:  zn = 0;
            1:  r = b;
            2:  r = (~a) & 65535;
            3:  begin sum = a + 1; r = sum % 65536; c = (sum > 65535); end
            4:  begin r = (a + 65535) % 65536; c = (a < 1); end
            5:  begin sum = a + b; r = sum % 65536; c = (sum > 65535); end
            6:  begin r = (a - b + 65536) % 65536; c = (a < b); end
            7:  r = a & b;
            8:  r = a | b;
            9:  begin r = (a << s) & 65535; if (s != 0) c = (a >> (16 - s)) & 1; end
            10: begin r = a >> s; if (s != 0) c = (a >> (s - 1)) & 1; end
            11: begin c = 1; zn = 0; end
            12: begin c = 0; zn = 0; end
            default: zn = 0;
        endcase
        nf = f;
        nf[2] = (c != 0);
        if (zn) begin
            nf[0] = (r == 0);
            nf[1] = (r >= 32768);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, imm;
        logic        src, fe;
        logic [2:0]  pre;
        logic [15:0] exp_val;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[18];

    // model state for the random run
    logic [2:0]  m_flags, m_saved, nf;
    logic [15:0] e_val, e_rd1, e_rd2, e_ldm, e_in;
    logic        e_rw, e_mw;
    logic [31:0] e_pc;
    int          r;
    bit          blocked, taken;

    initial begin
        vecs[0]  = '{4'd5,  16'hFFFF, 16'h0001, 16'h0000, 0, 1, 3'b000, 16'h0000, 3'b101};
        vecs[1]  = '{4'd6,  16'h0003, 16'h0005, 16'h0000, 0, 1, 3'b000, 16'hFFFE, 3'b110};
        vecs[2]  = '{4'd9,  16'h8001, 16'h0000, 16'h0001, 0, 1, 3'b000, 16'h0002, 3'b100};
        vecs[3]  = '{4'd9,  16'h1234, 16'h0000, 16'h0000, 0, 1, 3'b100, 16'h1234, 3'b100};
        vecs[4]  = '{4'd10, 16'h0003, 16'h0000, 16'h0001, 0, 1, 3'b000, 16'h0001, 3'b100};
        vecs[5]  = '{4'd1,  16'h0000, 16'h0000, 16'h8000, 1, 1, 3'b100, 16'h8000, 3'b110};
        vecs[6]  = '{4'd2,  16'hFFFF, 16'h0000, 16'h0000, 0, 1, 3'b010, 16'h0000, 3'b001};
        vecs[7]  = '{4'd3,  16'hFFFF, 16'h0000, 16'h0000, 0, 1, 3'b000, 16'h0000, 3'b101};
        vecs[8]  = '{4'd4,  16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b000, 16'hFFFF, 3'b110};
        vecs[9]  = '{4'd7,  16'hF0F0, 16'h0FF0, 16'h0000, 0, 1, 3'b100, 16'h00F0, 3'b100};
        vecs[10] = '{4'd8,  16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b010, 16'h0000, 3'b001};
        vecs[11] = '{4'd0,  16'h0005, 16'h0005, 16'h0000, 0, 1, 3'b111, 16'h0000, 3'b111};
        vecs[12] = '{4'd11, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 16'h0000, 3'b111};
        vecs[13] = '{4'd12, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b111, 16'h0000, 3'b011};
        vecs[14] = '{4'd5,  16'h0001, 16'h0002, 16'h0000, 0, 0, 3'b101, 16'h0003, 3'b101};
        vecs[15] = '{4'd6,  16'h0005, 16'h0005, 16'h0000, 0, 1, 3'b100, 16'h0000, 3'b001};
        vecs[16] = '{4'd10, 16'h8000, 16'h0000, 16'h000F, 0, 1, 3'b000, 16'h0001, 3'b000};
        vecs[17] = '{4'd9,  16'h0001, 16'h0000, 16'h000F, 0, 1, 3'b000, 16'h8000, 3'b010};

        idle();
        reset = 1;
        step(); step();
        chk("reset alu_value_out", alu_value_out, 0);
        chk("reset flags", flags, 0);
        chk("reset saved_flags", saved_flags, 0);
        chk("reset pc_out", pc_out, 0);
        chk("reset reg_write_out", reg_write_out, 0);
        chk("reset pc_choose_ex", pc_choose_ex, 0);
        reset = 0;

        // directed ALU table: preload flags, then apply the instruction
        for (int i = 0; i < 18; i++) begin
            idle();
            restore_flags_en = 1; restore_flags = vecs[i].pre;
            step();
            idle();
            alu_op = vecs[i].op; read_data1 = vecs[i].a; read_data2 = vecs[i].b;
            immediate = vecs[i].imm; alu_src = vecs[i].src; flag_enable = vecs[i].fe;
            step();
            chk($sformatf("vec%0d alu_value_out", i), alu_value_out, vecs[i].exp_val);
            chk($sformatf("vec%0d flags", i), flags, vecs[i].exp_flags);
        end

        // SUB sets C, then JC is taken and clears C
        idle();
        alu_op = 4'd6; read_data1 = 16'h0003; read_data2 = 16'h0005; flag_enable = 1;
        step();
        chk("sub value", alu_value_out, 16'hFFFE);
        chk("sub flags", flags, 3'b110);
        idle();
        jump_type = 3'd4; jump_target = 32'h1234_5678;
        #1;
        chk("jc pc_choose_ex", pc_choose_ex, 1);
        chk("jc pc_from_mux_ex", pc_from_mux_ex, 32'h1234_5678);
        step();
        chk("jc clears C", flags, 3'b010);
        idle();
        jump_type = 3'd2;
        #1;
        chk("jz not taken", pc_choose_ex, 0);

        // stall holds for two cycles, then flush inserts a bubble
        idle();
        alu_op = 4'd5; read_data1 = 7; read_data2 = 8; flag_enable = 1;
        reg_write = 1; pc = 32'hAAAA;
        step();
        idle();
        stall = 1; alu_op = 4'd6; read_data1 = 1; read_data2 = 2; flag_enable = 1;
        pc = 32'hBBBB; jump_type = 3'd1; jump_target = 32'hCAFE;
        #1;
        chk("stall pc_choose_ex", pc_choose_ex, 0);
        chk("stall pc_from_mux_ex", pc_from_mux_ex, 0);
        step(); step();
        chk("stall alu_value_out", alu_value_out, 16'h000F);
        chk("stall flags", flags, 3'b000);
        chk("stall reg_write_out", reg_write_out, 1);
        chk("stall pc_out", pc_out, 32'hAAAA);
        stall = 0; flush = 1; reg_write = 1; memory_write = 1;
        step();
        chk("flush reg_write_out", reg_write_out, 0);
        chk("flush memory_write_out", memory_write_out, 0);
        chk("flush alu_value_out", alu_value_out, 0);
        chk("flush pc_out", pc_out, 0);
        chk("flush flags", flags, 3'b000);

        // interrupt snapshot takes pre-update flags; restore beats flag_enable
        idle();
        restore_flags_en = 1; restore_flags = 3'b101;
        step();
        idle();
        alu_op = 4'd5; read_data1 = 1; read_data2 = 1; flag_enable = 1; interrupt = 1;
        step();
        chk("interrupt saved_flags", saved_flags, 3'b101);
        chk("interrupt flags", flags, 3'b000);
        idle();
        restore_flags_en = 1; restore_flags = 3'b010;
        alu_op = 4'd5; flag_enable = 1;
        step();
        chk("restore flags", flags, 3'b010);
        chk("restore saved kept", saved_flags, 3'b101);

        // reset mid-stream, then normal propagation
        idle();
        alu_op = 4'd5; read_data1 = 2; read_data2 = 2; reg_write = 1; pc = 32'h1;
        step();
        reset = 1;
        step();
        chk("midreset alu_value_out", alu_value_out, 0);
        chk("midreset reg_write_out", reg_write_out, 0);
        chk("midreset pc_out", pc_out, 0);
        chk("midreset flags", flags, 0);
        chk("midreset saved_flags", saved_flags, 0);
        reset = 0;
        alu_op = 4'd5; read_data1 = 2; read_data2 = 3; reg_write = 1; flag_enable = 1;
        step();
        chk("postreset alu_value_out", alu_value_out, 16'h0005);
        chk("postreset reg_write_out", reg_write_out, 1);

        // randomized run against the model
        idle();
        reset = 1;
        step();
        reset = 0;
        m_flags = 0; m_saved = 0;
        e_val = 0; e_rd1 = 0; e_rd2 = 0; e_ldm = 0; e_in = 0;
        e_rw = 0; e_mw = 0; e_pc = 0;
        for (int i = 0; i < 600; i++) begin
            reset            = ($urandom_range(0, 49) == 0);
            stall            = ($urandom_range(0, 7) == 0);
            flush            = ($urandom_range(0, 9) == 0);
            restore_flags_en = ($urandom_range(0, 11) == 0);
            restore_flags    = 3'($urandom_range(0, 7));
            interrupt        = ($urandom_range(0, 9) == 0);
            flag_enable      = ($urandom_range(0, 1) == 1);
            jump_type        = 3'($urandom_range(0, 4));
            jump_target      = $urandom;
            alu_op           = 4'($urandom_range(0, 12));
            alu_src          = ($urandom_range(0, 3) == 0);
            read_data1       = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            read_data2       = ($urandom_range(0, 5) == 0) ? read_data1 : 16'($urandom);
            immediate        = 16'($urandom);
            reg_write        = 1'($urandom);
            memory_write     = 1'($urandom);
            pc               = $urandom;
            input_port       = 16'($urandom);

            blocked = reset || stall || flush;
            case (jump_type)
                3'd1: taken = 1;
                3'd2: taken = m_flags[0];
                3'd3: taken = m_flags[1];
                3'd4: taken = m_flags[2];
                default: taken = 0;
            endcase
            if (blocked) taken = 0;
            #1;
            chk("rand pc_choose_ex", pc_choose_ex, taken);
            chk("rand pc_from_mux_ex", pc_from_mux_ex, blocked ? 32'd0 : jump_target);

            model_alu(int'(alu_op), int'(read_data1),
                      alu_src ? int'(immediate) : int'(read_data2),
                      int'(immediate[3:0]), m_flags, r, nf);

            if (reset) begin
                m_saved = 0;
            end else if (interrupt) begin
                m_saved = m_flags;
            end

            if (reset) begin
                m_flags = 0;
            end else if (restore_flags_en) begin
                m_flags = restore_flags;
            end else if (!(stall || flush)) begin
                if (flag_enable) m_flags = nf;
                else if (taken && jump_type != 3'd1) begin
                    if (jump_type == 3'd2) m_flags[0] = 0;
                    if (jump_type == 3'd3) m_flags[1] = 0;
                    if (jump_type == 3'd4) m_flags[2] = 0;
                end
            end

            if (reset || flush) begin
                e_val = 0; e_rd1 = 0; e_rd2 = 0; e_ldm = 0; e_in = 0;
                e_rw = 0; e_mw = 0; e_pc = 0;
            end else if (!stall) begin
                e_val = 16'(r); e_rd1 = read_data1; e_rd2 = read_data2; e_ldm = immediate;
                e_in = input_port; e_rw = reg_write; e_mw = memory_write; e_pc = pc;
            end

            step();
            chk("rand alu_value_out", alu_value_out, e_val);
            chk("rand flags", flags, m_flags);
            chk("rand saved_flags", saved_flags, m_saved);
            chk("rand read_data1_out", read_data1_out, e_rd1);
            chk("rand read_data2_out", read_data2_out, e_rd2);
            chk("rand LDM_value_out", LDM_value_out, e_ldm);
            chk("rand reg_write_out", reg_write_out, e_rw);
            chk("rand memory_write_out", memory_write_out, e_mw);
            chk("rand pc_out", pc_out, e_pc);
            chk("rand input_port_out", input_port_out, e_in);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipeline, between decode and `memory_stage`. It computes the 16-bit ALU result, owns the architectural flag register {C,N,Z} and resolves jumps. It registers all results and pass-through control into the EX/MEM buffer consumed by `memory_stage`. Stall and flush inputs from the hazard unit hold the buffer or insert a bubble.

## Interface
Parameters:
- none. Widths are fixed by `cpu_pkg`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the EX/MEM buffer and flags.
- `flush` in 1: load a bubble into the buffer.
- `read_data1`, `read_data2` in 16: operands A and B, already forwarded.
- `immediate` in 16: shift amount (bits 3:0) or LDM value.
- `alu_op` in 4 (`alu_op_t`): operation.
- `alu_src` in 1: 1 means B = `immediate`.
- `flag_enable` in 1: the operation updates flags.
- `jump_type` in 3 (`jump_t`): NONE/JMP/JZ/JN/JC.
- `jump_target` in 32: target PC.
- `interrupt` in 1: one-cycle pulse; snapshot flags.
- `restore_flags_en` in 1, `restore_flags` in 3: RTI flag restore.
- Pass-through inputs (registered to the matching `_out` port): `memory_read`, `memory_write`, `memory_push`, `memory_pop` (1 each), `memory_address_select` (2), `memory_write_src_select` (2), `reg_write` (1), `wb_sel` (2), `outport_enable` (1), `reg_write_address` (3), `pc` (32), `input_port` (16).
- Pass-through outputs: the `_out` copy of every pass-through input above.
- `alu_value_out` out 16: registered ALU result.
- `read_data1_out`, `read_data2_out` out 16: registered operands; these drive `std_address` and `ldd_address`.
- `LDM_value_out` out 16: registered `immediate`.
- `flags` out 3: current flag register; bit 0 = Z, bit 1 = N, bit 2 = C.
- `saved_flags` out 3: interrupt snapshot.
- `pc_choose_ex` out 1: combinational, jump taken this cycle.
- `pc_from_mux_ex` out 32: combinational, equals `jump_target`.

## Operation
- Operand selection: A = `read_data1`; B = `alu_src` ? `immediate` : `read_data2`.
- NOP: result 0, no flag change regardless of `flag_enable`.
- MOV: result B.
- NOT: result ~A.
- INC: A+1. DEC: A-1. ADD: A+B. SUB: A-B.
- AND, OR: bitwise on A and B.
- SHL, SHR: A shifted by `immediate[3:0]`.
- SETC: C=1. CLRC: C=0. Both produce result 0.
- Arithmetic is 17-bit internally; the result is the low 16 bits.
  - ADD/INC: C = bit 16 of the sum.
  - SUB/DEC: C = 1 on borrow (A < B, unsigned).
  - SHL/SHR: C = last bit shifted out; a shift of 0 leaves C unchanged.
  - NOT/AND/OR/MOV leave C unchanged.
- When `flag_enable`: Z = (result == 0) and N = result[15], for every op except SETC/CLRC.
- Jump resolution, combinational from the flag register as it stands this cycle:
  - JMP is always taken.
  - JZ/JN/JC are taken when Z/N/C = 1.
  - A taken conditional jump clears the tested flag at the clock edge.
- Flag register update priority at each edge, highest first:
  1. `reset`: flags = 0.
  2. `restore_flags_en`: flags = `restore_flags`.
  3. `stall` or `flush`: hold.
  4. `flag_enable`: ALU flags.
  5. Taken conditional jump: clear the tested flag.
- `interrupt`: `saved_flags` ← current `flags` at the edge, unaffected by `stall`. It is independent of a flag update in the same cycle, i.e. the pre-update value is saved.
- EX/MEM buffer, priority at each edge:
  1. `reset`: every output 0.
  2. `flush`: every control output (`reg_write`, `memory_*`, `outport_enable`, `wb_sel`, `*_select`) = 0 and every data output = 0.
  3. `stall`: hold every output.
  4. Otherwise: load the computed values.

## Timing
- Latency: 1 cycle from inputs to every `_out` port and to `flags`.
- `pc_choose_ex` and `pc_from_mux_ex` are combinational, with zero latency. They are forced to 0 during `reset`, `flush` and `stall`.
- A flag-setting instruction in cycle n is visible to a jump in cycle n+1; no flag forwarding is needed.
- Reset asserted mid-operation clears the buffer and flags at the next edge; in-flight pass-through data is lost.
- `stall` and `flush` together behave as `flush`.

## Structure
- `cpu_pkg` holds:
  - `alu_op_t` (4-bit enum: NOP, MOV, NOT, INC, DEC, ADD, SUB, AND, OR, SHL, SHR, SETC, CLRC).
  - `jump_t` (3-bit enum).
  - Flag index constants `FLAG_Z`=0, `FLAG_N`=1, `FLAG_C`=2.
- Sub-module `alu`: purely combinational. Takes A, B, op and the current flags; returns the result and next {C,N,Z}.
- Buffering uses the existing `var_reg` instances, with a stall enable and flush gating in front of their D inputs.

## Test plan
- ADD A=0xFFFF, B=0x0001, `flag_enable`=1 → `alu_value_out`=0x0000, Z=1, N=0, C=1 one cycle later.
- SUB A=0x0003, B=0x0005 → 0xFFFE, N=1, C=1, Z=0. In the next cycle JC → `pc_choose_ex`=1 and `pc_from_mux_ex`=`jump_target`; after that edge C=0.
- SHL A=0x8001 by 1 → 0x0002, C=1. SHL by 0 with C=1 → C stays 1.
- `stall`=1 for 2 cycles with new inputs applied → outputs and `flags` unchanged. A later `flush` with `reg_write`=1, `memory_write`=1 → both `_out`=0 and flags unchanged.
- `interrupt` pulse with flags=3'b101 while ADD sets Z=0 → `saved_flags`=3'b101. Then `restore_flags_en` with 3'b010 together with `flag_enable` → flags=3'b010.
- Reset mid-stream → every output 0 after one edge; the first instruction after release propagates normally.
